// File: rtl/sensor_capture_pkg.sv
// sensor_capture_pkg: shared state encodings and pointer width for the capture path
package sensor_capture_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;
  localparam int DEPTH_DEF = 8192;
  localparam int PTR_W = $clog2(DEPTH_DEF);
endpackage

// File: rtl/sensor_capture_ram.sv
// sensor_capture_ram: simple dual-port byte RAM with registered read, block-RAM inferable
module sensor_capture_ram #(
  parameter int DEPTH = 8192,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sensor_capture_ctl.sv
// sensor_capture_ctl: captures a programmed number of stream bytes, then lets the CPU pop them
module sensor_capture_ctl
  import sensor_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_CLEAR,
  input  logic        i_CLEAR_wstrobe,
  input  logic [31:0] i_CAPTURE_LEN,
  input  logic        i_ARM_wstrobe,
  input  logic        i_FIFO_READ_rstrobe,
  output logic [7:0]  o_FIFO_DATA,
  output logic [31:0] o_FIFO_COUNT,
  output logic [1:0]  o_STATUS,
  input  logic [7:0]  axis_vector_tdata,
  input  logic        axis_vector_tvalid,
  output logic        axis_vector_tready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, target, arm_len;
  logic [7:0] rdata;
  logic tready, clr, arm, pop, wr, last;
  assign clr = i_CLEAR_wstrobe & i_CLEAR;
  assign arm = i_ARM_wstrobe & (state != S_CAPTURE) & ~clr;
  assign pop = i_FIFO_READ_rstrobe & (state != S_CAPTURE) & (count != '0) & ~clr;
  assign wr = (state == S_CAPTURE) & tready & axis_vector_tvalid & ~clr;
  // captured bytes equal count during CAPTURE: the buffer is emptied on arm and pops are blocked
  assign last = wr & (count + 1'b1 == target);
  assign arm_len = (i_CAPTURE_LEN > FIFO_DEPTH) ? FULL : i_CAPTURE_LEN[AW:0];
  always_comb begin
    state_n = clr ? S_IDLE : arm ? (arm_len == '0 ? S_DONE : S_CAPTURE) : last ? S_DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tready <= 1'b0;
    end else if (arm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tready <= arm_len != '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
        count <= count + 1'b1;
        tready <= ~last;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      target <= '0;
      o_FIFO_DATA <= '0;
    end else begin
      if (arm) target <= arm_len;
      o_FIFO_DATA <= rdata;
    end
  end
  sensor_capture_ram #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(wr),
    .waddr(wr_ptr),
    .wdata(axis_vector_tdata),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  assign o_FIFO_COUNT = {{(31-AW){1'b0}}, count};
  assign o_STATUS = state;
  assign axis_vector_tready = tready;
endmodule

// File: tb/tb_sensor_capture_ctl.sv
// tb_sensor_capture_ctl: directed checks of capture, pop, clear, reset and length limits
module tb_sensor_capture_ctl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_CLEAR = 1'b0, i_CLEAR_wstrobe = 1'b0;
  logic [31:0] i_CAPTURE_LEN = '0;
  logic i_ARM_wstrobe = 1'b0, i_FIFO_READ_rstrobe = 1'b0;
  logic [7:0] o_FIFO_DATA;
  logic [31:0] o_FIFO_COUNT;
  logic [1:0] o_STATUS;
  logic [7:0] axis_vector_tdata = '0;
  logic axis_vector_tvalid = 1'b0;
  logic axis_vector_tready;
  int checks = 0, errors = 0;
  bit acc;
  int miss;
  sensor_capture_ctl #(.FIFO_DEPTH(8192)) dut (
    .clk(clk),
    .reset(reset),
    .i_CLEAR(i_CLEAR),
    .i_CLEAR_wstrobe(i_CLEAR_wstrobe),
    .i_CAPTURE_LEN(i_CAPTURE_LEN),
    .i_ARM_wstrobe(i_ARM_wstrobe),
    .i_FIFO_READ_rstrobe(i_FIFO_READ_rstrobe),
    .o_FIFO_DATA(o_FIFO_DATA),
    .o_FIFO_COUNT(o_FIFO_COUNT),
    .o_STATUS(o_STATUS),
    .axis_vector_tdata(axis_vector_tdata),
    .axis_vector_tvalid(axis_vector_tvalid),
    .axis_vector_tready(axis_vector_tready)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic arm(input logic [31:0] len);
    i_CAPTURE_LEN = len;
    i_ARM_wstrobe = 1'b1;
    tick();
    i_ARM_wstrobe = 1'b0;
  endtask
  task automatic push(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    axis_vector_tdata = b;
    axis_vector_tvalid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (axis_vector_tready) ok = 1'b1;
      tick();
    end
  endtask
  task automatic pop();
    i_FIFO_READ_rstrobe = 1'b1;
    tick();
    i_FIFO_READ_rstrobe = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    tick();
    tick();
    check("rst_count", o_FIFO_COUNT, 0);
    check("rst_status", {30'd0, o_STATUS}, 0);
    check("rst_tready", {31'd0, axis_vector_tready}, 0);
    check("rst_data", {24'd0, o_FIFO_DATA}, 0);
    reset = 1'b0;
    tick();
    // basic 4-byte capture with a fifth byte left pending
    arm(4);
    check("t1_tready_arm", {31'd0, axis_vector_tready}, 1);
    check("t1_status_arm", {30'd0, o_STATUS}, 1);
    push(8'h11, acc);
    check("t1_count1", o_FIFO_COUNT, 1);
    for (int i = 2; i <= 4; i++) begin
      push(8'(i * 8'h11), acc);
      check("t1_acc", {31'd0, acc}, 1);
    end
    push(8'h55, acc);
    check("t1_pend", {31'd0, acc}, 0);
    axis_vector_tvalid = 1'b0;
    check("t1_tready_done", {31'd0, axis_vector_tready}, 0);
    check("t1_status", {30'd0, o_STATUS}, 2);
    check("t1_count", o_FIFO_COUNT, 4);
    tick();
    for (int i = 1; i <= 4; i++) begin
      check("t1_data", {24'd0, o_FIFO_DATA}, i * 32'h11);
      pop();
    end
    check("t1_count_end", o_FIFO_COUNT, 0);
    // 8-byte capture with tvalid gaps
    arm(8);
    for (int i = 0; i < 8; i++) begin
      axis_vector_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      push(8'(8'hA0 + i), acc);
    end
    axis_vector_tvalid = 1'b0;
    check("t2_status", {30'd0, o_STATUS}, 2);
    check("t2_count", o_FIFO_COUNT, 8);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t2_data", {24'd0, o_FIFO_DATA}, 32'hA0 + i);
      pop();
    end
    check("t2_count_end", o_FIFO_COUNT, 0);
    // oversize length clamps to the buffer depth
    arm(20000);
    miss = 0;
    for (int i = 0; i < 8192; i++) begin
      push(8'(i), acc);
      if (!acc) miss++;
    end
    push(8'hEE, acc);
    axis_vector_tvalid = 1'b0;
    check("t3_miss", miss, 0);
    check("t3_extra", {31'd0, acc}, 0);
    check("t3_status", {30'd0, o_STATUS}, 2);
    check("t3_count", o_FIFO_COUNT, 8192);
    tick();
    check("t3_head", {24'd0, o_FIFO_DATA}, 0);
    pop();
    check("t3_data1", {24'd0, o_FIFO_DATA}, 1);
    check("t3_count_pop", o_FIFO_COUNT, 8191);
    arm(3);
    check("t3_rearm_count", o_FIFO_COUNT, 0);
    check("t3_rearm_status", {30'd0, o_STATUS}, 1);
    for (int i = 0; i < 3; i++) push(8'(8'hB0 + i), acc);
    axis_vector_tvalid = 1'b0;
    check("t3_count3", o_FIFO_COUNT, 3);
    check("t3_status3", {30'd0, o_STATUS}, 2);
    tick();
    check("t3_head3", {24'd0, o_FIFO_DATA}, 32'hB0);
    pop();
    check("t3_data3", {24'd0, o_FIFO_DATA}, 32'hB1);
    // clear together with arm
    i_CLEAR = 1'b1;
    i_CLEAR_wstrobe = 1'b1;
    arm(5);
    i_CLEAR_wstrobe = 1'b0;
    check("t4_status", {30'd0, o_STATUS}, 0);
    check("t4_count", o_FIFO_COUNT, 0);
    check("t4_tready", {31'd0, axis_vector_tready}, 0);
    // clear mid-capture after five bytes
    arm(10);
    for (int i = 0; i < 5; i++) push(8'(i), acc);
    axis_vector_tvalid = 1'b0;
    check("t4_mid_count", o_FIFO_COUNT, 5);
    i_CLEAR_wstrobe = 1'b1;
    tick();
    i_CLEAR_wstrobe = 1'b0;
    check("t4_mid_status", {30'd0, o_STATUS}, 0);
    check("t4_mid_count0", o_FIFO_COUNT, 0);
    check("t4_mid_tready", {31'd0, axis_vector_tready}, 0);
    // zero length goes straight to DONE
    arm(0);
    check("t5_status", {30'd0, o_STATUS}, 2);
    check("t5_tready", {31'd0, axis_vector_tready}, 0);
    check("t5_count", o_FIFO_COUNT, 0);
    pop();
    check("t5_pop_count", o_FIFO_COUNT, 0);
    // arm and read strobes during CAPTURE are ignored
    arm(6);
    push(8'hC0, acc);
    push(8'hC1, acc);
    i_CAPTURE_LEN = 2;
    i_ARM_wstrobe = 1'b1;
    i_FIFO_READ_rstrobe = 1'b1;
    push(8'hC2, acc);
    i_ARM_wstrobe = 1'b0;
    i_FIFO_READ_rstrobe = 1'b0;
    check("t6_count", o_FIFO_COUNT, 3);
    check("t6_status", {30'd0, o_STATUS}, 1);
    for (int i = 3; i < 6; i++) push(8'(8'hC0 + i), acc);
    axis_vector_tvalid = 1'b0;
    check("t6_count6", o_FIFO_COUNT, 6);
    check("t6_status6", {30'd0, o_STATUS}, 2);
    tick();
    check("t6_head", {24'd0, o_FIFO_DATA}, 32'hC0);
    pop();
    check("t6_data1", {24'd0, o_FIFO_DATA}, 32'hC1);
    // reset mid-capture
    arm(10);
    for (int i = 0; i < 3; i++) push(8'(i), acc);
    axis_vector_tvalid = 1'b0;
    reset = 1'b1;
    tick();
    check("t7_count", o_FIFO_COUNT, 0);
    check("t7_status", {30'd0, o_STATUS}, 0);
    check("t7_tready", {31'd0, axis_vector_tready}, 0);
    check("t7_data", {24'd0, o_FIFO_DATA}, 0);
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
